// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053_pkg: opcodes, funct3 codes, ALU op enum and decode helpers for the RV64I core
package ysyx_220053_pkg;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;
  // funct3 values 001/101 are shifts, which this core does not implement
  function automatic logic f3_ok(input logic [2:0] f3);
    return !(f3 == 3'b001 || f3 == 3'b101);
  endfunction
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
    return f3 == F3_SLT  ? ALU_SLT  :
           f3 == F3_SLTU ? ALU_SLTU :
           f3 == F3_XOR  ? ALU_XOR  :
           f3 == F3_OR   ? ALU_OR   :
           f3 == F3_AND  ? ALU_AND  : ALU_ADD;
  endfunction
endpackage

// File: rtl/ysyx_220053_if.sv
// ysyx_220053_if: core <-> imem/debug bundle; master = core (drives pc, halt, dbg_rdata), slave = environment (drives instr_i, dbg_raddr)
interface ysyx_220053_if;
  logic [31:0] instr_i;
  logic [63:0] pc;
  logic        halt;
  logic [4:0]  dbg_raddr;
  logic [63:0] dbg_rdata;
  modport master (input instr_i, dbg_raddr, output pc, halt, dbg_rdata);
  modport slave (output instr_i, dbg_raddr, input pc, halt, dbg_rdata);
endinterface

// File: rtl/ysyx_220053_regfile.sv
// ysyx_220053_regfile: 32xXLEN register file; ports clk/rst (async clear), we/waddr/wdata sync write, raddr1/2 + dbg_raddr combinational reads; x0 reads 0
module ysyx_220053_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  logic [XLEN-1:0] mem [32];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 32; i++) mem[i] <= '0;
    else if (we && waddr != 5'd0) mem[waddr] <= wdata;
  assign rdata1    = raddr1 == 5'd0 ? '0 : mem[raddr1];
  assign rdata2    = raddr2 == 5'd0 ? '0 : mem[raddr2];
  assign dbg_rdata = dbg_raddr == 5'd0 ? '0 : mem[dbg_raddr];
endmodule

// File: rtl/ysyx_220053_core.sv
// ysyx_220053_core: single-cycle RV64I subset core; ports clk, rst (async), bus (master: instr_i/dbg_raddr in, pc/halt/dbg_rdata out); CORE_EBREAK_EN enables halt on EBREAK
module ysyx_220053_core
  import ysyx_220053_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 64
) (
  input logic           clk,
  input logic           rst,
  ysyx_220053_if.master bus
);
  logic [31:0] instr;
  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [XLEN-1:0] pc_q, pc_next, pc_plus4, rs1_v, rs2_v, imm_i, imm_u, imm_j;
  logic [XLEN-1:0] a, b, alu_y, jalr_sum;
  alu_op_e op;
  logic wen, stall;
  assign instr    = bus.instr_i;
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign f3       = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign f7       = instr[31:25];
  assign imm_i    = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u    = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j    = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_sum = rs1_v + imm_i;
  always_comb begin
    op      = ALU_ADD;
    a       = rs1_v;
    b       = imm_i;
    wen     = 1'b0;
    pc_next = pc_plus4;
    if (opcode == OP_IMM && f3_ok(f3)) begin
      op  = f3_to_alu(f3);
      wen = 1'b1;
    end else if (opcode == OP && f3_ok(f3) && (f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_ADD))) begin
      op  = f7[5] ? ALU_SUB : f3_to_alu(f3);
      b   = rs2_v;
      wen = 1'b1;
    end else if (opcode == LUI) begin
      op  = ALU_PASS_B;
      b   = imm_u;
      wen = 1'b1;
    end else if (opcode == AUIPC) begin
      a   = pc_q;
      b   = imm_u;
      wen = 1'b1;
    end else if (opcode == JAL) begin
      op      = ALU_PASS_B;
      b       = pc_plus4;
      wen     = 1'b1;
      pc_next = pc_q + imm_j;
    end else if (opcode == JALR && f3 == F3_ADD) begin
      op      = ALU_PASS_B;
      b       = pc_plus4;
      wen     = 1'b1;
      pc_next = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end
  always_comb begin
    alu_y = b;
    case (op)
      ALU_ADD:  alu_y = a + b;
      ALU_SUB:  alu_y = a - b;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  alu_y = a ^ b;
      ALU_OR:   alu_y = a | b;
      ALU_AND:  alu_y = a & b;
      default:  alu_y = b;
    endcase
  end
`ifdef CORE_EBREAK_EN
  logic halt_q, is_ebreak;
  assign is_ebreak = instr == EBREAK_INSN;
  // EBREAK itself does not advance pc, so the halted pc points at the EBREAK
  assign stall     = halt_q | is_ebreak;
  always_ff @(posedge clk or posedge rst)
    if (rst) halt_q <= 1'b0;
    else if (is_ebreak) halt_q <= 1'b1;
  assign bus.halt = halt_q;
`else
  assign stall    = 1'b0;
  assign bus.halt = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= RESET_PC;
    else if (!stall) pc_q <= pc_next;
  assign bus.pc = pc_q;
  ysyx_220053_regfile #(.XLEN(XLEN)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we        (wen && !stall),
    .waddr     (rd),
    .wdata     (alu_y),
    .raddr1    (rs1),
    .rdata1    (rs1_v),
    .raddr2    (rs2),
    .rdata2    (rs2_v),
    .dbg_raddr (bus.dbg_raddr),
    .dbg_rdata (bus.dbg_rdata)
  );
endmodule

// File: tb/tb_ysyx_220053_core.sv
// tb_ysyx_220053_core: directed-vector bench; stimulus queues expected pc/reg/halt values, a monitor pops and compares
module tb_ysyx_220053_core;
  logic clk, rst;
  ysyx_220053_if bus();
  ysyx_220053_core dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [63:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] BASE = 64'h8000_0000;
  initial clk = 1'b0;
  always #100 clk = ~clk;
  task automatic push(input int k, input logic [4:0] a, input logic [63:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask
  task automatic exp_pc(input logic [63:0] v, input string n);
    push(0, 5'd0, v, {n, ".pc"});
  endtask
  task automatic exp_x(input logic [4:0] a, input logic [63:0] v, input string n);
    push(1, a, v, $sformatf("%s.x%0d", n, a));
  endtask
  task automatic exp_halt(input logic v, input string n);
    push(2, 5'd0, {63'b0, v}, {n, ".halt"});
  endtask
  task automatic drained(input string n);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s.drain: %0d expectations pending, required 0", n, sb.size());
      sb.delete();
    end
  endtask
  task automatic exec(input logic [31:0] ins, input string n);
    @(negedge clk);
    bus.instr_i = ins;
    @(posedge clk);
    #1;
    drained(n);
  endtask
  // monitor: compares each queued expectation against the live DUT outputs
  initial begin
    exp_t e;
    logic [63:0] act;
    bus.dbg_raddr = 5'd0;
    forever begin
      if (sb.size() == 0) #1;
      else begin
        e = sb.pop_front();
        if (e.kind == 1) bus.dbg_raddr = e.addr;
        #1;
        act = e.kind == 0 ? bus.pc : e.kind == 1 ? bus.dbg_rdata : {63'b0, bus.halt};
        n_checks++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %h, required %h", e.name, act, e.val);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    bus.instr_i = 32'h0050_0293;
    repeat (2) @(posedge clk);
    #20 rst = 1'b0;
    for (int i = 0; i < 32; i++) exp_x(5'(i), 64'd0, "reset");
    exp_pc(BASE, "reset");
    exp_halt(1'b0, "reset");
    exec(32'hFFF0_0093, "addi_m1");
    exp_pc(BASE + 4, "addi_m1"); exp_x(1, ONES, "addi_m1");
    exec(32'h0050_8013, "addi_x0");
    exp_pc(BASE + 8, "addi_x0"); exp_x(0, 64'd0, "addi_x0"); exp_x(1, ONES, "addi_x0");
    exec(32'h1234_5137, "lui");
    exp_pc(BASE + 12, "lui"); exp_x(2, 64'h1234_5000, "lui");
    exec(32'h6781_0113, "addi_x2");
    exp_x(2, 64'h1234_5678, "addi_x2");
    exec(32'h0020_31B3, "sltu");
    exp_x(3, 64'd1, "sltu");
    exec(32'h0000_A233, "slt");
    exp_x(4, 64'd1, "slt"); exp_pc(BASE + 24, "slt");
    exec(32'h4011_02B3, "sub");
    exp_x(5, 64'h1234_5679, "sub");
    exec(32'h0F00_C313, "xori");
    exp_x(6, 64'hFFFF_FFFF_FFFF_FF0F, "xori");
    exec(32'hFFF1_3393, "sltiu");
    exp_x(7, 64'd1, "sltiu");
    exec(32'h0000_1417, "auipc");
    exp_x(8, 64'h8000_1024, "auipc"); exp_pc(BASE + 40, "auipc");
    exec(32'h0000_0000, "illegal");
    exp_pc(BASE + 44, "illegal"); exp_x(0, 64'd0, "illegal"); exp_x(1, ONES, "illegal"); exp_x(2, 64'h1234_5678, "illegal");
    exec(32'h0010_9493, "slli_nop");
    exp_pc(BASE + 48, "slli_nop"); exp_x(9, 64'd0, "slli_nop"); exp_x(1, ONES, "slli_nop");
    @(negedge clk);
    bus.instr_i = 32'h0010_0513;
    #50 rst = 1'b1;
    @(posedge clk);
    #20 rst = 1'b0;
    drained("abort");
    exp_pc(BASE, "abort"); exp_x(10, 64'd0, "abort"); exp_x(1, 64'd0, "abort"); exp_x(2, 64'd0, "abort"); exp_x(8, 64'd0, "abort");
    exp_halt(1'b0, "abort");
    exec(32'h0100_00EF, "jal");
    exp_x(1, 64'h8000_0004, "jal"); exp_pc(64'h8000_0010, "jal");
    exec(32'h0000_8067, "jalr");
    exp_pc(64'h8000_0004, "jalr"); exp_x(0, 64'd0, "jalr"); exp_x(1, 64'h8000_0004, "jalr");
    exec(32'h0030_80E7, "jalr_odd");
    exp_pc(64'h8000_0006, "jalr_odd"); exp_x(1, 64'h8000_0008, "jalr_odd");
    exec(32'hFFBF_F06F, "jal_back");
    exp_pc(BASE, "jal_back"); exp_x(1, 64'h8000_0008, "jal_back");
    exec(32'h0010_0073, "ebreak");
`ifdef CORE_EBREAK_EN
    exp_halt(1'b1, "ebreak"); exp_pc(BASE, "ebreak");
    for (int i = 0; i < 10; i++) begin
      exec(32'hFFF0_0093, "halted");
      exp_pc(BASE, "halted"); exp_x(1, 64'h8000_0008, "halted"); exp_halt(1'b1, "halted");
    end
`else
    exp_halt(1'b0, "ebreak"); exp_pc(BASE + 4, "ebreak"); exp_x(1, 64'h8000_0008, "ebreak");
`endif
    @(negedge clk);
    rst = 1'b1;
    #20 rst = 1'b0;
    drained("rst_clear");
    exp_halt(1'b0, "rst_clear"); exp_pc(BASE, "rst_clear"); exp_x(1, 64'd0, "rst_clear");
    @(negedge clk);
    drained("end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
